// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int WORD_BYTES          = 4;
  localparam int HDR_BYTES           = 2;
  localparam int DEFAULT_DEPTH_WORDS = 1024;

  // States in which the loader takes bytes from the stream.
  function automatic logic takes_bytes(state_t s);
    return (s == HDR0) || (s == HDR1) || (s == RECV);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 30
) ();

  logic                     start;
  logic                     byte_valid;
  logic [7:0]               byte_in;
  logic                     byte_ready;
  logic                     regWE;
  logic [ADDR_WIDTH-1:0]    Addr;
  logic [31:0]              DataIn;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic                     cpu_run;
  logic [HDR_BYTES*8-1:0]   words_written;

  modport master (
    output start, byte_valid, byte_in,
    input  byte_ready, regWE, Addr, DataIn, busy, done, error, cpu_run, words_written
  );

  modport slave (
    input  start, byte_valid, byte_in,
    output byte_ready, regWE, Addr, DataIn, busy, done, error, cpu_run, words_written
  );

endinterface

// File: rtl/program_loader_timeout.sv
// Inter-byte idle timer: down-counter reloaded on clear, expires at zero.
module program_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on clear, otherwise count down while enabled and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero reached after TIMEOUT_CYCLES-1 idle clocks; this edge is the expiry.
  assign expire_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles big-endian words from a framed byte stream and
// writes them to instruction memory from address 0, holding the CPU until done.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR0  | waiting for word-count MSB (no timeout)
//   HDR1  | waiting for word-count LSB
//   RECV  | shifting payload bytes into the word register
//   WRITE | one-cycle memory write of the assembled word
//   DONE  | program complete, CPU released
//   ERR   | oversize program or inter-byte timeout
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int DEPTH_WORDS    = DEFAULT_DEPTH_WORDS,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam int N_W   = HDR_BYTES * 8;

  state_t             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        word_q, word_d;
  logic [31:0]        data_q, data_d;
  logic [N_W-1:0]     addr_q, addr_d;
  logic [N_W-1:0]     ww_q, ww_d;
  logic               byte_ready_q, byte_ready_d;
  logic               regwe_q, regwe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic accept;
  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expire;

  assign accept     = bus.byte_valid & byte_ready_q;
  assign tmo_enable = (state_q == HDR1) || (state_q == RECV);
  assign tmo_clear  = accept || (state_d != state_q);

  program_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expire_o (tmo_expire)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    addr_d  = addr_q;
    ww_d    = ww_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d = HDR0;
          addr_d  = '0;
          ww_d    = '0;
          idx_d   = '0;
        end
      end
      HDR0: begin
        if (accept) begin
          n_d     = {bus.byte_in, n_q[7:0]};
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          n_d = {n_q[15:8], bus.byte_in};
          if (n_d == '0) begin
            state_d = DONE;
          end else if (32'(n_d) > DEPTH_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = RECV;
            addr_d  = '0;
            idx_d   = '0;
          end
        end else if (tmo_expire) begin
          state_d = ERR;
        end
      end
      RECV: begin
        if (accept) begin
          word_d = {word_q[23:0], bus.byte_in};
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
            data_d  = word_d;
            state_d = WRITE;
          end
        end else if (tmo_expire) begin
          state_d = ERR;
        end
      end
      WRITE: begin
        ww_d = ww_q + 1'b1;
        if (ww_d == n_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    byte_ready_d = takes_bytes(state_d);
    regwe_d      = (state_d == WRITE);
    busy_d       = takes_bytes(state_d) || (state_d == WRITE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      ww_q         <= '0;
      byte_ready_q <= 1'b0;
      regwe_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      ww_q         <= ww_d;
      byte_ready_q <= byte_ready_d;
      regwe_q      <= regwe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.byte_ready    = byte_ready_q;
  assign bus.regWE         = regwe_q;
  assign bus.Addr          = ADDR_WIDTH'(addr_q);
  assign bus.DataIn        = data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.cpu_run       = done_q;
  assign bus.words_written = ww_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames checked against a frame-level model of the loader.
module tb_program_loader;

  localparam int DEPTH = 1024;
  localparam int TMO   = 1000;

  logic clk = 1'b0;
  logic reset;

  program_loader_if #(.ADDR_WIDTH(30)) bus ();

  program_loader #(
    .ADDR_WIDTH     (30),
    .DEPTH_WORDS    (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  frame[$];
  int          wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic        we_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory port: log every write seen during a WRITE cycle.
  always @(negedge clk) begin
    if (bus.regWE === 1'b1) begin
      wr_addr_log.push_back(int'(bus.Addr));
      wr_data_log.push_back(bus.DataIn);
      check("ready_low_during_write", 64'(bus.byte_ready), 64'd0);
      check("we_single_cycle", 64'(we_prev), 64'd0);
    end
    we_prev = bus.regWE;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic int pick_gap(input int mode, input int k);
    if (mode == 1) begin
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(900, 990));
      return int'($urandom_range(0, 3));
    end
    if (mode == 2) begin
      if (k == 0) return 1500;
      if (k == 1 || k == 5 || k == 7) return TMO - 1;
    end
    return 0;
  endfunction

  task automatic build_random(input int n);
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < n * 4; i++) frame.push_back(8'($urandom));
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    while (bus.byte_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("byte_accepted", 64'(bus.byte_ready), 64'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int glitch_k);
    wr_addr_log.delete();
    wr_data_log.delete();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < frame.size(); k++) begin
      if (k == glitch_k) bus.start = 1'b1;
      send_byte(frame[k], pick_gap(mode, k));
      bus.start = 1'b0;
      if (k >= 2 && ((k - 2) % 4) == 3) begin
        check($sformatf("we_latency_w%0d", (k - 2) / 4), 64'(bus.regWE), 64'd1);
        check($sformatf("datain_w%0d", (k - 2) / 4), 64'(bus.DataIn),
              64'({frame[k-3], frame[k-2], frame[k-1], frame[k]}));
      end
    end
  endtask

  task automatic check_result(input string tag);
    int n;
    n = int'({frame[0], frame[1]});
    for (int i = 0; i < 20 && bus.done !== 1'b1 && bus.error !== 1'b1; i++) @(negedge clk);
    if (n > DEPTH) begin
      check({tag, "_error"}, 64'(bus.error), 64'd1);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
      check({tag, "_cpu_run"}, 64'(bus.cpu_run), 64'd0);
      check({tag, "_nwrites"}, 64'(wr_addr_log.size()), 64'd0);
    end else begin
      check({tag, "_done"}, 64'(bus.done), 64'd1);
      check({tag, "_cpu_run"}, 64'(bus.cpu_run), 64'd1);
      check({tag, "_error"}, 64'(bus.error), 64'd0);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_words_written"}, 64'(bus.words_written), 64'(n));
      check({tag, "_nwrites"}, 64'(wr_addr_log.size()), 64'(n));
      for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_log[i]), 64'(i));
        check($sformatf("%s_data%0d", tag, i), 64'(wr_data_log[i]),
              64'({frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]}));
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_regWE", 64'(bus.regWE), 64'd0);
    check("rst_Addr", 64'(bus.Addr), 64'd0);
    check("rst_DataIn", 64'(bus.DataIn), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_cpu_run", 64'(bus.cpu_run), 64'd0);
    check("rst_words_written", 64'(bus.words_written), 64'd0);

    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    send_frame(0, -1);
    check_result("happy");

    frame = '{8'h00, 8'h00};
    send_frame(0, -1);
    check("zero_done_next_cycle", 64'(bus.done), 64'd1);
    check_result("zero");

    frame = '{8'h04, 8'h01};
    send_frame(0, -1);
    check("oversize_error_next_cycle", 64'(bus.error), 64'd1);
    check_result("oversize");

    build_random(1);
    send_frame(1, -1);
    check_result("recover");

    build_random(DEPTH);
    send_frame(0, -1);
    check_result("depth_max");

    build_random(2);
    send_frame(2, -1);
    check_result("gap_edge");

    for (int r = 0; r < 4; r++) begin
      build_random(int'($urandom_range(1, 6)));
      send_frame(1, (r == 1) ? 3 : -1);
      check_result($sformatf("rand%0d", r));
    end

    frame = '{8'h00, 8'h01, 8'hA5, 8'h5A};
    send_frame(0, -1);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_yet_error", 64'(bus.error), 64'd0);
    check("tmo_not_yet_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("tmo_error", 64'(bus.error), 64'd1);
    check("tmo_busy", 64'(bus.busy), 64'd0);
    check("tmo_cpu_run", 64'(bus.cpu_run), 64'd0);
    check("tmo_nwrites", 64'(wr_addr_log.size()), 64'd0);

    frame = '{8'h00, 8'h02, 8'h11, 8'h22};
    send_frame(0, -1);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("async_rst_regWE", 64'(bus.regWE), 64'd0);
    check("async_rst_Addr", 64'(bus.Addr), 64'd0);
    check("async_rst_DataIn", 64'(bus.DataIn), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_error", 64'(bus.error), 64'd0);
    check("async_rst_cpu_run", 64'(bus.cpu_run), 64'd0);
    check("async_rst_words_written", 64'(bus.words_written), 64'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("start_in_reset_busy", 64'(bus.busy), 64'd0);
    check("start_in_reset_ready", 64'(bus.byte_ready), 64'd0);

    build_random(2);
    send_frame(1, -1);
    check_result("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory's write port (clk, regWE, Addr, DataIn).
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses starting at 0.
- Holds the CPU fetch unit (PC update) idle until the program is fully written.
- Replaces the static hex-file preload for on-board program download.

Parameters:
- ADDR_WIDTH, 30, width of the word address driven to the instruction memory.
- DEPTH_WORDS, 1024, instruction memory capacity in words; a larger program is rejected.
- TIMEOUT_CYCLES, 1000, maximum idle clocks allowed between bytes once a transfer has started.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a download when idle, done or error.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_in  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- regWE  output  1  instruction memory write enable.
- Addr  output  ADDR_WIDTH  instruction memory word address.
- DataIn  output  32  instruction word to write.
- busy  output  1  download in progress.
- done  output  1  sticky; program fully written.
- error  output  1  sticky; oversize program or timeout.
- cpu_run  output  1  PC may advance; equals done.
- words_written  output  16  count of words committed so far.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; word count, byte index and timeout counter cleared.
- Handshake:
  - A byte transfers on a rising edge where byte_valid & byte_ready are both 1.
  - byte_ready is 1 only in states HDR0, HDR1 and RECV. It is 0 in IDLE, WRITE, DONE and ERR.
- Frame format:
  - Two header bytes carry the word count N, 16-bit, MSB first.
  - Then N*4 payload bytes; each word is sent MSB first.
- States:
  - IDLE: start -> HDR0.
  - HDR0: accepted byte -> N[15:8]; go to HDR1.
  - HDR1: accepted byte -> N[7:0], then:
    - N == 0 -> DONE.
    - N > DEPTH_WORDS -> ERR.
    - Otherwise -> RECV with Addr = 0 and byte index 0.
  - RECV:
    - Each accepted byte shifts into the word register: word <= {word[23:0], byte_in}.
    - On the 4th byte (index 3) -> WRITE.
  - WRITE: exactly one cycle with regWE = 1, DataIn = the assembled word, Addr = current address. Next edge:
    - words_written increments.
    - If words_written+1 == N -> DONE.
    - Otherwise Addr increments and state returns to RECV.
  - DONE: done = 1, cpu_run = 1; start -> HDR0 and done clears.
  - ERR: error = 1, cpu_run stays 0; start -> HDR0 and error clears.
- Output timing:
  - busy = 1 in HDR0, HDR1, RECV and WRITE.
  - All outputs are registered.
  - regWE rises the cycle after the 4th byte is accepted.
  - Write latency from 4th-byte accept to memory update: 2 edges.
- Timeout:
  - The counter is active in HDR1 and RECV only; HDR0 waits indefinitely.
  - The counter clears on every accepted byte and on each state entry.
  - When it reaches TIMEOUT_CYCLES-1 without an accepted byte -> ERR.
  - If a byte is accepted in the same cycle, the byte wins and no timeout occurs.
- Start handling:
  - start while busy is ignored.
  - Starting a new download (start from IDLE, DONE or ERR) clears words_written and Addr to 0.
- Width rules: Addr zero-extends the internal word counter to ADDR_WIDTH. Addr never wraps because N ≤ DEPTH_WORDS.
- Reset mid-operation: immediately returns to IDLE with regWE = 0. A partially written program stays in memory, but cpu_run = 0.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, HDR0, HDR1, RECV, WRITE, DONE, ERR.
  - Constants: WORD_BYTES = 4, HDR_BYTES = 2, default DEPTH_WORDS.
- One natural sub-module, loader_timeout: a counter with clear/enable inputs and an expire output.

Test Plan:
- Happy path: start, header 0x0002, bytes 20 08 00 05 | 00 00 00 0C -> regWE pulses twice; Addr=0 with DataIn=0x20080005, then Addr=1 with DataIn=0x0000000C; done=1, cpu_run=1, words_written=2.
- Zero length: header 0x0000 -> DONE the cycle after the 2nd byte; regWE never asserts.
- Oversize: header 0x0401 (1025) -> error=1, no writes; a following start plus a valid 1-word frame succeeds and clears error.
- Backpressure and gaps: byte_valid toggling randomly with gaps < 1000 cycles -> same memory contents as the happy path. Confirm byte_ready=0 during WRITE and that no byte is lost.
- Timeout: after 2 payload bytes, hold byte_valid=0 for 1000 cycles -> ERR; regWE never asserts and busy falls.
- Async reset asserted mid-RECV (not on a clock edge) -> all outputs 0 immediately, state IDLE; start ignored while reset is high.
